// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch controller: PC sequencing, imem reads, decode FIFO
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int unsigned IMEM_AW  = 10,
    parameter int unsigned DEPTH    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        pc,
    output logic [31:0]        npc,
    output logic               imem_rd,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [31:0]        out_pc,
    output logic               fetch_err
);

    // Pointer width and count width (count must represent DEPTH itself).
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0]   IMEM_WORDS = 32'(1) << IMEM_AW;
    localparam logic [CW:0]   DEPTH_OCC  = (CW + 1)'(DEPTH);

    // FIFO storage: instruction word plus the PC it was fetched from.
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   instr_d [DEPTH];
    logic [31:0]   ipc_q   [DEPTH];
    logic [31:0]   ipc_d   [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // One outstanding imem read and the PC that produced it.
    logic          inflight_q, inflight_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;

    // Sticky illegal-fetch flag; only reset clears it.
    logic          err_q, err_d;

    logic [31:0]   pc_off;
    logic [31:0]   pc_word;
    logic          pc_legal;
    logic          deq;
    logic          push;
    logic [CW:0]   occ;
    logic          issue;

    // PC legality: word aligned and inside the instruction-memory window.
    always_comb begin
        pc_off   = pc - RESET_PC;
        pc_word  = pc_off >> 2;
        pc_legal = (pc[1:0] == 2'b00) && (pc >= RESET_PC) && (pc_word < IMEM_WORDS);
    end

    // Issue decision: a read may start only if its response is guaranteed a FIFO slot.
    always_comb begin
        out_valid = !reset && (count_q != '0);
        deq       = out_valid && out_ready;
        occ       = {1'b0, count_q} - (CW + 1)'(deq) + (CW + 1)'(inflight_q);
        issue     = !reset && !redirect && !err_q && pc_legal && (occ < DEPTH_OCC);
        push      = inflight_q && !redirect && !reset;
    end

    // Output drive: memory request, next PC selection and FIFO head.
    always_comb begin
        imem_rd   = issue;
        imem_addr = pc_off[IMEM_AW+1:2];
        if (reset) begin
            npc = RESET_PC;
        end else if (redirect) begin
            npc = redirect_pc;
        end else if (issue) begin
            npc = pc + 32'd4;
        end else begin
            npc = pc;
        end
        out_instr = instr_q[rd_ptr_q];
        out_pc    = ipc_q[rd_ptr_q];
        fetch_err = err_q && !reset;
    end

    // Next-state: reset and redirect flush everything; otherwise push/pop the FIFO.
    always_comb begin
        instr_d       = instr_q;
        ipc_d         = ipc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        inflight_d    = issue;
        inflight_pc_d = pc;
        err_d         = err_q;

        if (reset) begin
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            inflight_d = 1'b0;
            err_d      = 1'b0;
        end else if (redirect) begin
            // The decoder may still take the head this cycle; the flush discards the rest
            // and the response of any outstanding read.
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                instr_d[wr_ptr_q] = imem_rdata;
                ipc_d[wr_ptr_q]   = inflight_pc_q;
                wr_ptr_d          = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(deq);
            if (!pc_legal) begin
                err_d = 1'b1;
            end
        end
    end

    // Control state register.
    always_ff @(posedge clk) begin
        rd_ptr_q      <= rd_ptr_d;
        wr_ptr_q      <= wr_ptr_d;
        count_q       <= count_d;
        inflight_q    <= inflight_d;
        inflight_pc_q <= inflight_pc_d;
        err_q         <= err_d;
    end

    // FIFO payload storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge clk) begin
        instr_q <= instr_d;
        ipc_q   <= ipc_d;
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - table-driven bench with delivery scoreboard for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc = 32'h0;
    logic [31:0] npc;
    logic        imem_rd;
    logic [9:0]  imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    fetch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .npc         (npc),
        .imem_rd     (imem_rd),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    // PC register and synchronous instruction memory around the controller.
    always @(posedge clk) pc <= npc;
    always @(posedge clk) if (imem_rd) imem_rdata <= {20'h0, imem_addr, 2'b00} + 32'h100;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        ov;
        logic [31:0] opc;
        logic        rd;
        logic [9:0]  addr;
        logic [31:0] np;
        logic        er;
        int          sbm;
        logic [31:0] sbpc;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(input logic rst, input logic rdy, input logic redir,
                                input logic [31:0] rpc, input logic ov, input logic [31:0] opc,
                                input logic rd, input logic [9:0] addr, input logic [31:0] np,
                                input logic er, input int sbm, input logic [31:0] sbpc);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.ov = ov; v.opc = opc; v.rd = rd; v.addr = addr; v.np = np; v.er = er;
        v.sbm = sbm; v.sbpc = sbpc;
        return v;
    endfunction

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // Expected delivery stream: sequential PCs from a start point, data = offset + 0x100.
    task automatic sb_restart(input logic [31:0] start);
        exp_t e;
        sb.delete();
        for (int k = 0; k < 16; k++) begin
            e.pc    = start + 32'(4 * k);
            e.instr = start - 32'h3000 + 32'(4 * k) + 32'h100;
            sb.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; out_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        //            rst rdy red rpc           ov opc           rd addr     npc           er sb pc
        vecs.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 0, 1, 32'h3000));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h000, 32'h3004, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h001, 32'h3008, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3000, 1, 10'h002, 32'h300C, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3004, 1, 10'h003, 32'h3010, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3008, 1, 10'h004, 32'h3014, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h300C, 0, 10'h000, 32'h3014, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h300C, 0, 10'h000, 32'h3014, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h300C, 0, 10'h000, 32'h3014, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h300C, 1, 10'h005, 32'h3018, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3010, 1, 10'h006, 32'h301C, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3014, 1, 10'h007, 32'h3020, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h3040, 1, 32'h3018, 0, 10'h000, 32'h3040, 0, 1, 32'h3040));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h010, 32'h3044, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h011, 32'h3048, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3040, 1, 10'h012, 32'h304C, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h3044, 0, 10'h000, 32'h304C, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h3044, 0, 10'h000, 32'h304C, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 32'h3080, 1, 32'h3044, 0, 10'h000, 32'h3080, 0, 1, 32'h3080));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h020, 32'h3084, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h021, 32'h3088, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3080, 1, 10'h022, 32'h308C, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h3002, 1, 32'h3084, 0, 10'h000, 32'h3002, 0, 2, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3002, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3002, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h3000, 0, 32'h0,    0, 10'h000, 32'h3000, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 1, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 0, 0, 32'h0));
        vecs.push_back(mk(1, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 0, 1, 32'h3000));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h000, 32'h3004, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 1, 32'h3FFC, 0, 32'h0,    0, 10'h000, 32'h3FFC, 0, 1, 32'h3FFC));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h3FF, 32'h4000, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h4000, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3FFC, 0, 10'h000, 32'h4000, 1, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h4000, 1, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 0, 1, 32'h3000));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 10'h000, 32'h3004, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    0, 32'h0,    1, 10'h001, 32'h3008, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h3000, 0, 10'h000, 32'h3008, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 32'h0,    1, 32'h3000, 0, 10'h000, 32'h3008, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 32'h0,    0, 32'h0,    0, 10'h000, 32'h3000, 0, 1, 32'h3000));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h000, 32'h3004, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    0, 32'h0,    1, 10'h001, 32'h3008, 0, 0, 32'h0));
        vecs.push_back(mk(0, 1, 0, 32'h0,    1, 32'h3000, 1, 10'h002, 32'h300C, 0, 0, 32'h0));

        for (int i = 0; i < vecs.size(); i++) begin
            reset       = vecs[i].rst;
            out_ready   = vecs[i].rdy;
            redirect    = vecs[i].redir;
            redirect_pc = vecs[i].rpc;
            @(negedge clk);

            chk("out_valid", i, 32'(out_valid), 32'(vecs[i].ov));
            chk("imem_rd",   i, 32'(imem_rd),   32'(vecs[i].rd));
            chk("npc",       i, npc,            vecs[i].np);
            chk("fetch_err", i, 32'(fetch_err), 32'(vecs[i].er));
            if (vecs[i].ov) chk("out_pc", i, out_pc, vecs[i].opc);
            if (vecs[i].rd) chk("imem_addr", i, 32'(imem_addr), 32'(vecs[i].addr));

            // Every instruction the decoder takes must be the next one in program order.
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_deq", i, out_pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", i, out_pc, e.pc);
                    chk("sb_instr", i, out_instr, e.instr);
                end
            end

            if (vecs[i].sbm == 1) sb_restart(vecs[i].sbpc);
            else if (vecs[i].sbm == 2) sb.delete();

            @(posedge clk);
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
